uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Round-robin transmit scheduler that shares one `uart_tx` serializer among `N_REQ` byte producers. Each cycle it is free, it picks one pending requester, captures that requester's byte and pulses `enable` into the serializer. It then tracks `active`/`done` until the frame has fully left the line. A per-requester lock lets one producer send a multi-byte message without other producers interleaving bytes.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `GAP_CYCLES`, 0, idle clock cycles inserted between consecutive frames (0..65535)
- `ID_W`, 2, width of `owner_id`; must equal clog2(`N_REQ`)

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  N_REQ  requester i has a byte pending
- `req_lock`  in  N_REQ  requester i wants to keep the grant after the current byte
- `req_data`  in  8*N_REQ  byte of requester i at bits [8i+7:8i]
- `req_ready`  out  N_REQ  one-cycle pulse: requester i's byte was captured
- `tx_readdata`  out  8  byte to the serializer (`readdata`)
- `tx_enable`  out  1  one-cycle start pulse to the serializer (`enable`)
- `tx_active`  in  1  serializer `active`
- `tx_done`  in  1  serializer `done`
- `grant`  out  N_REQ  one-hot current owner; 0 when no owner
- `owner_id`  out  ID_W  index of current/last owner
- `busy`  out  1  high in every state except ARB
- `byte_sent`  out  1  one-cycle pulse when a frame has completed

## Operation
States:
- ARB
- LAUNCH
- WAIT_DONE
- WAIT_IDLE
- GAP

Reset:
- State ARB.
- All outputs 0.
- Internal `last` = N_REQ-1, so requester 0 has priority first.
- `locked` = 0.
- Gap counter 0.

ARB:
- The scheduler launches only if `tx_active`=0 and `tx_done`=0.
- Unlocked: the winner is the first i with `req_valid[i]`=1, searching circularly from `last`+1.
- Locked: only `owner_id` is eligible.
  - If `req_valid[owner]`=0 and `req_lock[owner]`=0, `locked` clears and normal arbitration resumes the next cycle.
- On a winner w, at the clock edge:
  - `tx_readdata` <= `req_data[w]`
  - `tx_enable` <= 1
  - `req_ready[w]` <= 1
  - `grant` <= onehot(w), `owner_id` <= w, `last` <= w
  - `locked` <= `req_lock[w]`
  - go to LAUNCH.
- No winner: stay in ARB; `grant` = onehot(owner) if `locked`, else 0.

LAUNCH (1 cycle):
- `tx_enable` and `req_ready` are high during this cycle only; both clear on exit.
- Go to WAIT_DONE.

WAIT_DONE:
- Wait for `tx_done`=1, then go to WAIT_IDLE.

WAIT_IDLE:
- Wait for `tx_done`=0 and `tx_active`=0.
- Then pulse `byte_sent` for 1 cycle and clear `grant` if `locked`=0.
- Go to GAP if `GAP_CYCLES`>0, else ARB.

GAP:
- Count `GAP_CYCLES` cycles, then go to ARB.

Other rules:
- `tx_readdata` holds its value until the next capture.
- `req_data` is sampled only at the ARB capture edge.
- A requester must change or drop `req_valid`/`req_data` on the edge where it sees `req_ready`=1.

## Timing
- Capture latency: `req_valid` high in an ARB cycle t -> `tx_enable`/`req_ready` high in cycle t+1.
- Serializer response: `tx_active` rises at t+2, from the serializer.
- Back-to-back frames with GAP_CYCLES=0:
  - The serializer returns to idle; its done/active clear one cycle after it enters idle.
  - The scheduler sees this in WAIT_IDLE, goes to ARB (1 cycle), then launches.
- Simultaneous requests: exactly one `req_ready` bit is ever high.
- `req_valid` falling in the same ARB cycle it would win: the requester is not granted.
- `tx_done` already high on entry to WAIT_DONE: advance immediately.
- Reset mid-frame: immediate return to reset values. No `req_ready` or `byte_sent` pulse is produced for the aborted frame. The serializer shares `reset`.
- `GAP_CYCLES` counter is 16 bits and has no wrap-around.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants: ARB=3'd0, LAUNCH=3'd1, WAIT_DONE=3'd2, WAIT_IDLE=3'd3, GAP=3'd4
  - the frame bit-count constant.
- One sub-module, `rr_pick`: a purely combinational circular priority search.
  - Inputs: `req`[N_REQ], `last`[ID_W].
  - Outputs: `found`, `idx`[ID_W].
- Benches use the existing `uart_tx` with `clock_bit`=3 as the serializer model.

## Test plan
- Single requester: `req_valid`=4'b0001, `req_data[7:0]`=8'hA5 -> `tx_enable` and `req_ready[0]` pulse one cycle later; line shows 0,1,0,1,0,0,1,0,1,1; one `byte_sent` pulse.
- All four valid, no lock, data 8'h10..8'h13 -> frames go out in order 0,1,2,3; second round in order 0,1,2,3; exactly one `req_ready` bit per frame.
- Lock: req1 sends 8'h31/8'h32/8'h33 with `req_lock`=1,1,0 while req0 and req2 are continuously valid -> three consecutive req1 frames, then req2 then req0.
- `GAP_CYCLES`=5 -> exactly 5 cycles between `byte_sent` and the next `tx_enable` when work is pending.
- Reset asserted in the middle of data bits -> all outputs 0 the same cycle; after release, a pending req3 is served first only if req0..2 are idle, else req0.
- Lock held with `req_valid`=0, then `req_lock` dropped -> `grant` stays onehot(owner) until the drop, then clears and arbitration resumes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit scheduler and its serializer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_pkg;

    // Scheduler state encoding
    localparam logic [2:0] ARB       = 3'd0;
    localparam logic [2:0] LAUNCH    = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] WAIT_IDLE = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;

    // Bits per frame on the line: start + 8 data + stop
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/rr_pick.sv
// Circular priority search: first set bit of req strictly after last, wrapping.
// Latency: purely combinational.
// Backpressure: none.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    int              sum;
    logic [ID_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest pending requester wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            sum = int'(last) + k;
            if (sum >= N_REQ) begin
                sum = sum - N_REQ;
            end
            cand = ID_W'(sum);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte serializer: start bit, 8 data bits LSB first, stop bit, clock_bit cycles per bit.
// Latency: enable at cycle t -> active and start bit at t+1; done pulses one cycle after the stop bit.
// Backpressure: enable is ignored while a frame is in flight or done is still high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clock_bit = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] readdata,
    output logic       tx,
    output logic       active,
    output logic       done
);

    localparam logic [15:0] CYC_LAST = 16'(clock_bit - 1);
    localparam logic [3:0]  BIT_LAST = 4'(FRAME_BITS - 1);

    logic        sending;
    logic [15:0] cyc_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shreg;

    // Frame shifter; done/active linger one idle cycle before clearing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx      <= 1'b1;
            active  <= 1'b0;
            done    <= 1'b0;
            sending <= 1'b0;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (sending) begin
            if (cyc_cnt == CYC_LAST) begin
                cyc_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    sending <= 1'b0;
                    done    <= 1'b1;
                    tx      <= 1'b1;
                end else begin
                    tx      <= shreg[0];
                    shreg   <= {1'b0, shreg[8:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
        end else if (done) begin
            done   <= 1'b0;
            active <= 1'b0;
        end else if (enable) begin
            sending <= 1'b1;
            active  <= 1'b1;
            tx      <= 1'b0;
            shreg   <= {1'b1, readdata};
            cyc_cnt <= '0;
            bit_cnt <= '0;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers, with per-owner lock.
// Latency: req_valid seen in ARB cycle t -> tx_enable/req_ready pulse in t+1; one frame in flight.
// Backpressure: requesters hold req_valid/req_data until req_ready; no capture unless serializer idle.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 0,
    parameter int ID_W       = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_lock,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_readdata,
    output logic               tx_enable,
    input  logic               tx_active,
    input  logic               tx_done,
    output logic [N_REQ-1:0]   grant,
    output logic [ID_W-1:0]    owner_id,
    output logic               busy,
    output logic               byte_sent
);

    localparam logic [15:0]     GAP_LAST  = 16'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_REQ - 1);

    logic [2:0]      state;
    logic [ID_W-1:0] last;
    logic            locked;
    logic [15:0]     gap_cnt;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic            lock_drop;
    logic            tx_idle;
    logic [7:0]      req_byte [N_REQ];

    function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_byte
        assign req_byte[g] = req_data[8*g +: 8];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req_valid),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy = (state != ARB);

    // Winner selection: a locked owner is the only eligible requester
    always_comb begin
        tx_idle   = !tx_active && !tx_done;
        lock_drop = locked && !req_valid[owner_id] && !req_lock[owner_id];
        if (locked) begin
            win_found = req_valid[owner_id];
            win_idx   = owner_id;
        end else begin
            win_found = pick_found;
            win_idx   = pick_idx;
        end
    end

    // Scheduler FSM with capture registers and one-cycle pulse outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ARB;
            last        <= LAST_INIT;
            locked      <= 1'b0;
            gap_cnt     <= '0;
            req_ready   <= '0;
            tx_readdata <= '0;
            tx_enable   <= 1'b0;
            grant       <= '0;
            owner_id    <= '0;
            byte_sent   <= 1'b0;
        end else begin
            tx_enable <= 1'b0;
            req_ready <= '0;
            byte_sent <= 1'b0;
            case (state)
                ARB: begin
                    if (win_found && tx_idle) begin
                        tx_readdata <= req_byte[win_idx];
                        tx_enable   <= 1'b1;
                        req_ready   <= onehot(win_idx);
                        grant       <= onehot(win_idx);
                        owner_id    <= win_idx;
                        last        <= win_idx;
                        locked      <= req_lock[win_idx];
                        state       <= LAUNCH;
                    end else begin
                        if (lock_drop) begin
                            locked <= 1'b0;
                        end
                        grant <= (locked && !lock_drop) ? onehot(owner_id) : '0;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (!tx_done && !tx_active) begin
                        byte_sent <= 1'b1;
                        if (!locked) begin
                            grant <= '0;
                        end
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES > 0) ? GAP : ARB;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ARB;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: scheduler plus uart_tx serializer, GAP_CYCLES=0 and GAP_CYCLES=5 instances.
// Latency: n/a.
// Backpressure: requester models hold each byte until they see req_ready.
module tb_uart_tx_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_lock, req_ready, grant;
    logic [31:0] req_data;
    logic [7:0]  tx_readdata;
    logic        tx_enable, tx_active, tx_done, busy, byte_sent, txd;
    logic [1:0]  owner_id;

    logic [3:0]  g_valid, g_lock, g_ready, g_grant;
    logic [31:0] g_data;
    logic [7:0]  g_readdata;
    logic        g_enable, g_active, g_done, g_busy, g_byte_sent, g_txd;
    logic [1:0]  g_owner;

    uart_tx_sched #(.N_REQ(4), .GAP_CYCLES(0), .ID_W(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_data(req_data), .req_ready(req_ready), .tx_readdata(tx_readdata),
        .tx_enable(tx_enable), .tx_active(tx_active), .tx_done(tx_done),
        .grant(grant), .owner_id(owner_id), .busy(busy), .byte_sent(byte_sent)
    );
    uart_tx #(.clock_bit(3)) ser (
        .clock(clock), .reset(reset), .enable(tx_enable), .readdata(tx_readdata),
        .tx(txd), .active(tx_active), .done(tx_done)
    );

    uart_tx_sched #(.N_REQ(4), .GAP_CYCLES(5), .ID_W(2)) dut_g (
        .clock(clock), .reset(reset), .req_valid(g_valid), .req_lock(g_lock),
        .req_data(g_data), .req_ready(g_ready), .tx_readdata(g_readdata),
        .tx_enable(g_enable), .tx_active(g_active), .tx_done(g_done),
        .grant(g_grant), .owner_id(g_owner), .busy(g_busy), .byte_sent(g_byte_sent)
    );
    uart_tx #(.clock_bit(3)) ser_g (
        .clock(clock), .reset(reset), .enable(g_enable), .readdata(g_readdata),
        .tx(g_txd), .active(g_active), .done(g_done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester model: per-requester byte lists with lock flags
    logic [7:0] rdat [4][4];
    logic       rlk  [4][4];
    int         rlen [4];
    int         rpos [4];
    logic [3:0] hold_lock;

    task automatic drive();
        logic [3:0]  v, l;
        logic [31:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < 4; i++) begin
            if (rpos[i] < rlen[i]) begin
                v = {1'b1, v[3:1]};
                l = {rlk[i][rpos[i]] | hold_lock[2'(i)], l[3:1]};
                d = {rdat[i][rpos[i]], d[31:8]};
            end else begin
                v = {1'b0, v[3:1]};
                l = {hold_lock[2'(i)], l[3:1]};
                d = {8'h00, d[31:8]};
            end
        end
        req_valid = v;
        req_lock  = l;
        req_data  = d;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic lk);
        rdat[i][rlen[i]] = d;
        rlk[i][rlen[i]]  = lk;
        rlen[i]++;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 4; i++) begin
            rlen[i] = 0;
            rpos[i] = 0;
        end
        hold_lock = '0;
        drive();
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[2'(i)]) rpos[i]++;
        end
        drive();
    endtask

    // Monitor: enable/byte_sent events, sampled on the falling edge
    int         cyc = 0;
    int         sent_cnt = 0;
    int         last_sent_cyc = 0;
    int         last_gap = -1;
    logic [7:0] en_data [$];
    int         en_cyc [$];
    int         g_sent_cyc = 0;
    int         g_gap = -1;
    logic [7:0] g_first = 8'h00;

    always @(negedge clock) begin
        cyc++;
        if (tx_enable) begin
            en_data.push_back(tx_readdata);
            en_cyc.push_back(cyc);
            last_gap = cyc - last_sent_cyc;
            chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
        end
        if (byte_sent) begin
            sent_cnt++;
            last_sent_cyc = cyc;
        end
        if (g_byte_sent) g_sent_cyc = cyc;
        if (g_enable && g_sent_cyc == 0) g_first = g_readdata;
        if (g_enable && g_sent_cyc > 0 && g_gap < 0) g_gap = cyc - g_sent_cyc;
    end

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        step();
        step();
        en_data.delete();
        en_cyc.delete();
        reset = 1'b0;
    endtask

    task automatic wait_en(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (en_data.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(en_data.size()), 32'(n));
    endtask

    logic [7:0] exp2 [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    logic [7:0] exp3 [7] = '{8'h31, 8'h32, 8'h33, 8'h21, 8'h01, 8'h22, 8'h02};

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] line_bits;
        int         s0;
        int         k;

        reset   = 1'b1;
        g_valid = '0;
        g_lock  = '0;
        g_data  = 32'h0000_0077;
        clear_reqs();
        step();
        // Reset values
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_enable", 32'(tx_enable), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_owner", 32'(owner_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sent", 32'(byte_sent), 32'd0);
        chk("rst_data", 32'(tx_readdata), 32'd0);
        do_reset();

        // Single requester 0, byte A5
        push(0, 8'hA5, 1'b0);
        drive();
        s0 = sent_cnt;
        step();
        chk("t1_enable", 32'(tx_enable), 32'd1);
        chk("t1_ready", 32'(req_ready), 32'b0001);
        chk("t1_data", 32'(tx_readdata), 32'hA5);
        chk("t1_grant", 32'(grant), 32'b0001);
        step();
        chk("t1_enable_off", 32'(tx_enable), 32'd0);
        chk("t1_ready_off", 32'(req_ready), 32'd0);
        chk("t1_active", 32'(tx_active), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        step();
        line_bits = {txd, 9'b0};
        for (int j = 1; j < 10; j++) begin
            step(); step(); step();
            line_bits = {txd, line_bits[9:1]};
        end
        chk("t1_line", 32'(line_bits), 32'b1101001010);
        step(); step(); step();
        chk("t1_sent_early", 32'(byte_sent), 32'd0);
        step();
        chk("t1_sent", 32'(byte_sent), 32'd1);
        chk("t1_grant_clr", 32'(grant), 32'd0);
        chk("t1_busy_clr", 32'(busy), 32'd0);
        step();
        chk("t1_sent_cnt", 32'(sent_cnt - s0), 32'd1);

        // All four valid, two rounds
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(i, 8'h10 + 8'(i), 1'b0);
            push(i, 8'h20 + 8'(i), 1'b0);
        end
        drive();
        wait_en("t2_count", 8, 400);
        for (int i = 0; i < 8; i++) begin
            if (i < en_data.size()) chk("t2_order", 32'(en_data[i]), 32'(exp2[i]));
        end
        if (en_cyc.size() >= 2) chk("t2_spacing", 32'(en_cyc[1] - en_cyc[0]), 32'd34);
        chk("t2_sent_to_en", 32'(last_gap), 32'd1);

        // Lock: req1 sends three bytes, others join after its first capture
        do_reset();
        push(1, 8'h31, 1'b1);
        push(1, 8'h32, 1'b1);
        push(1, 8'h33, 1'b0);
        drive();
        wait_en("t3_first", 1, 20);
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b0);
        drive();
        wait_en("t3_count", 7, 400);
        for (int i = 0; i < 7; i++) begin
            if (i < en_data.size()) chk("t3_order", 32'(en_data[i]), 32'(exp3[i]));
        end

        // Reset in the middle of data bits
        do_reset();
        push(2, 8'h55, 1'b0);
        drive();
        wait_en("t4_first", 1, 20);
        for (int i = 0; i < 8; i++) step();
        chk("t4_owner_pre", 32'(owner_id), 32'd2);
        s0 = sent_cnt;
        reset = 1'b1;
        #1;
        chk("t4_enable", 32'(tx_enable), 32'd0);
        chk("t4_ready", 32'(req_ready), 32'd0);
        chk("t4_grant", 32'(grant), 32'd0);
        chk("t4_owner", 32'(owner_id), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_data", 32'(tx_readdata), 32'd0);
        chk("t4_active", 32'(tx_active), 32'd0);
        clear_reqs();
        push(0, 8'h0A, 1'b0);
        push(3, 8'h3A, 1'b0);
        drive();
        step();
        en_data.delete();
        en_cyc.delete();
        reset = 1'b0;
        wait_en("t4_count", 2, 150);
        if (en_data.size() >= 2) begin
            chk("t4_first_req0", 32'(en_data[0]), 32'h0A);
            chk("t4_then_req3", 32'(en_data[1]), 32'h3A);
        end
        chk("t4_sent_cnt", 32'(sent_cnt - s0), 32'd1);
        do_reset();
        push(3, 8'h3B, 1'b0);
        drive();
        wait_en("t4_only3", 1, 20);
        if (en_data.size() >= 1) chk("t4_req3_alone", 32'(en_data[0]), 32'h3B);

        // Lock held with nothing pending, then dropped
        do_reset();
        hold_lock[2] = 1'b1;
        push(2, 8'h42, 1'b0);
        drive();
        wait_en("t5_first", 1, 20);
        push(0, 8'h05, 1'b0);
        drive();
        s0 = sent_cnt;
        k = 0;
        while (sent_cnt == s0 && k < 60) begin
            step();
            k++;
        end
        chk("t5_sent", 32'(sent_cnt - s0), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("t5_grant_held", 32'(grant), 32'b0100);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_no_other", 32'(en_data.size()), 32'd1);
        hold_lock[2] = 1'b0;
        drive();
        step();
        chk("t5_grant_clr", 32'(grant), 32'd0);
        chk("t5_no_en_yet", 32'(tx_enable), 32'd0);
        step();
        chk("t5_en_req0", 32'(tx_enable), 32'd1);
        chk("t5_data_req0", 32'(tx_readdata), 32'h05);
        chk("t5_grant_req0", 32'(grant), 32'b0001);

        // GAP_CYCLES=5 instance with continuous work
        g_valid = 4'b0001;
        k = 0;
        while (g_gap < 0 && k < 300) begin
            step();
            k++;
        end
        chk("t6_gap", 32'(g_gap), 32'd6);
        chk("t6_data", 32'(g_first), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
